snake_engine: RTL and testbench

//  Parametrised successor to the game-logic snake updater. Holds the snake body in a

---
 rtl/snake_pkg.sv | 71 +++++++
 rtl/snake_body_ram.sv | 30 +++
 rtl/snake_engine.sv | 273 +++++++++++++++++++++++++++
 tb/tb_snake_engine.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake engine: grid points, headings, game
// states, internal FSM encoding and single-cell step functions.
package snake_pkg;

    localparam int COORD_W     = 8;
    localparam int DEF_GRID_W  = 40;
    localparam int DEF_GRID_H  = 30;
    localparam int DEF_MAX_LEN = 64;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } direction_t;

    typedef enum logic [1:0] {
        initial_state = 2'd0,
        game_state    = 2'd1,
        pause_state   = 2'd2,
        over_state    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        FSM_IDLE  = 3'd0,
        FSM_SPAWN = 3'd1,
        FSM_FSCAN = 3'd2,
        FSM_MOVE  = 3'd3,
        FSM_CSCAN = 3'd4,
        FSM_EAT   = 3'd5
    } fsm_t;

    function automatic direction_t opposite(input direction_t d);
        direction_t r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_RIGHT: r = DIR_LEFT;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            default:   r = DIR_UP;
        endcase
        return r;
    endfunction

    // One extra bit so that 0-1 shows up as a large (off-grid) value.
    function automatic logic [COORD_W:0] step_x(input logic [COORD_W-1:0] x, input direction_t d);
        logic [COORD_W:0] r;
        case (d)
            DIR_RIGHT: r = {1'b0, x} + {{COORD_W{1'b0}}, 1'b1};
            DIR_LEFT:  r = {1'b0, x} - {{COORD_W{1'b0}}, 1'b1};
            default:   r = {1'b0, x};
        endcase
        return r;
    endfunction

    function automatic logic [COORD_W:0] step_y(input logic [COORD_W-1:0] y, input direction_t d);
        logic [COORD_W:0] r;
        case (d)
            DIR_DOWN: r = {1'b0, y} + {{COORD_W{1'b0}}, 1'b1};
            DIR_UP:   r = {1'b0, y} - {{COORD_W{1'b0}}, 1'b1};
            default:  r = {1'b0, y};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_body_ram.sv
// Snake body ring storage: one write port and two independent synchronous
// read ports (collision/food scan and renderer).
module snake_body_ram
    import snake_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  point_t        wdata,
    input  logic [AW-1:0] scan_addr,
    output point_t        scan_data,
    input  logic [AW-1:0] rd_addr,
    output point_t        rd_data
);

    point_t mem_r [DEPTH];

    // Write port plus two registered read ports.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        scan_data <= mem_r[scan_addr];
        rd_data   <= mem_r[rd_addr];
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game engine: ring-buffer body, step-driven movement, sequential
// self-collision / food scans and food spawning. Edge wrap enabled by SNAKE_WRAP_EN.
module snake_engine
    import snake_pkg::*;
#(
    parameter int GRID_W  = DEF_GRID_W,
    parameter int GRID_H  = DEF_GRID_H,
    parameter int MAX_LEN = DEF_MAX_LEN,
    localparam int AW = $clog2(MAX_LEN),
    localparam int LW = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  state_t        state,
    input  direction_t    direction,
    input  logic          step,
    input  logic [31:0]   rand_x,
    input  logic [31:0]   rand_y,
    input  logic [AW-1:0] rd_idx,
    output point_t        rd_seg,
    output point_t        head,
    output logic [LW-1:0] length,
    output point_t        food,
    output logic          has_food,
    output logic          food_eaten,
    output logic          lose,
    output logic          win,
    output logic          busy
);

    localparam logic [COORD_W:0] X_LIM     = (COORD_W+1)'(GRID_W);
    localparam logic [COORD_W:0] Y_LIM     = (COORD_W+1)'(GRID_H);
    localparam logic [31:0]      GRID_W_32 = 32'(GRID_W);
    localparam logic [31:0]      GRID_H_32 = 32'(GRID_H);
    localparam point_t           INIT_HEAD = '{x: COORD_W'(GRID_W / 2), y: COORD_W'(GRID_H / 2)};
    localparam logic [LW-1:0]    ONE_LEN   = LW'(1);
    localparam logic [LW-1:0]    FULL_LEN  = LW'(MAX_LEN);

    fsm_t          fsm_r, fsm_nx_s;
    logic [AW-1:0] head_ptr_r, head_ptr_nx_s;
    point_t        head_r, head_nx_s, food_r, food_nx_s, cand_r, cand_nx_s;
    direction_t    heading_r, heading_nx_s, move_dir_s;
    logic [LW-1:0] length_r, length_nx_s, scan_idx_r, scan_idx_nx_s;
    logic          has_food_r, has_food_nx_s, food_eaten_r, food_eaten_nx_s;
    logic          lose_r, lose_nx_s, win_r, win_nx_s, busy_r, busy_nx_s;
    logic          pending_r, pending_nx_s, scan_vld_r, scan_vld_nx_s, scan_last_r, scan_last_nx_s;
    logic [COORD_W:0] nx_x_s, nx_y_s;
    point_t        new_head_s, target_s, scan_data_s, ram_wdata_s;
    logic          off_s, issue_s, hit_s, done_s, take_s, frozen_s, ram_we_s;
    logic [AW-1:0] ram_waddr_s, scan_addr_s, rd_addr_s;

    snake_body_ram #(.DEPTH(MAX_LEN)) u_body (
        .clock     (clock),
        .we        (ram_we_s),
        .waddr     (ram_waddr_s),
        .wdata     (ram_wdata_s),
        .scan_addr (scan_addr_s),
        .scan_data (scan_data_s),
        .rd_addr   (rd_addr_s),
        .rd_data   (rd_seg)
    );

    // Candidate head for the next move; reversals keep the current heading.
    always_comb begin
        move_dir_s = (direction == opposite(heading_r)) ? heading_r : direction;
        nx_x_s     = step_x(head_r.x, move_dir_s);
        nx_y_s     = step_y(head_r.y, move_dir_s);
        new_head_s = head_r;
`ifdef SNAKE_WRAP_EN
        off_s = 1'b0;
        if (nx_x_s >= X_LIM) begin
            new_head_s.x = (move_dir_s == DIR_LEFT) ? COORD_W'(GRID_W - 1) : {COORD_W{1'b0}};
        end else begin
            new_head_s.x = nx_x_s[COORD_W-1:0];
        end
        if (nx_y_s >= Y_LIM) begin
            new_head_s.y = (move_dir_s == DIR_UP) ? COORD_W'(GRID_H - 1) : {COORD_W{1'b0}};
        end else begin
            new_head_s.y = nx_y_s[COORD_W-1:0];
        end
`else
        off_s        = (nx_x_s >= X_LIM) || (nx_y_s >= Y_LIM);
        new_head_s.x = nx_x_s[COORD_W-1:0];
        new_head_s.y = nx_y_s[COORD_W-1:0];
`endif
    end

    // Scan pipeline: issue segment scan_idx, compare the registered read one cycle later.
    always_comb begin
        scan_addr_s = head_ptr_r - scan_idx_r[AW-1:0];
        rd_addr_s   = head_ptr_r - rd_idx;
        target_s    = (fsm_r == FSM_FSCAN) ? cand_r : head_r;
        issue_s     = (scan_idx_r < length_r);
        hit_s       = scan_vld_r && (scan_data_s == target_s);
        done_s      = scan_vld_r ? scan_last_r : !issue_s;
        frozen_s    = lose_r || win_r;
    end

    // Next-state and datapath update logic.
    always_comb begin
        fsm_nx_s        = fsm_r;
        head_ptr_nx_s   = head_ptr_r;
        head_nx_s       = head_r;
        food_nx_s       = food_r;
        cand_nx_s       = cand_r;
        heading_nx_s    = heading_r;
        length_nx_s     = length_r;
        has_food_nx_s   = has_food_r;
        food_eaten_nx_s = 1'b0;
        lose_nx_s       = lose_r;
        win_nx_s        = win_r;
        pending_nx_s    = pending_r;
        scan_idx_nx_s   = scan_idx_r;
        scan_vld_nx_s   = 1'b0;
        scan_last_nx_s  = 1'b0;
        take_s          = 1'b0;
        ram_we_s        = 1'b0;
        ram_waddr_s     = head_ptr_r;
        ram_wdata_s     = new_head_s;
        busy_nx_s       = 1'b0;
        if (reset || state == initial_state) begin
            fsm_nx_s      = FSM_IDLE;
            head_ptr_nx_s = {AW{1'b0}};
            head_nx_s     = INIT_HEAD;
            food_nx_s     = '{x: {COORD_W{1'b0}}, y: {COORD_W{1'b0}}};
            heading_nx_s  = DIR_RIGHT;
            length_nx_s   = ONE_LEN;
            has_food_nx_s = 1'b0;
            lose_nx_s     = 1'b0;
            win_nx_s      = 1'b0;
            pending_nx_s  = 1'b0;
            scan_idx_nx_s = {LW{1'b0}};
            ram_we_s      = 1'b1;
            ram_waddr_s   = {AW{1'b0}};
            ram_wdata_s   = INIT_HEAD;
        end else begin
            case (fsm_r)
                FSM_IDLE: begin
                    if (state == game_state && !frozen_s) begin
                        if (!has_food_r) begin
                            fsm_nx_s = FSM_SPAWN;
                        end else if (step || pending_r) begin
                            fsm_nx_s = FSM_MOVE;
                            take_s   = 1'b1;
                        end else begin
                            fsm_nx_s = FSM_IDLE;
                        end
                    end else begin
                        fsm_nx_s = FSM_IDLE;
                    end
                end
                FSM_SPAWN: begin
                    cand_nx_s     = '{x: COORD_W'(rand_x % GRID_W_32), y: COORD_W'(rand_y % GRID_H_32)};
                    scan_idx_nx_s = {LW{1'b0}};
                    fsm_nx_s      = FSM_FSCAN;
                end
                FSM_FSCAN: begin
                    scan_idx_nx_s  = scan_idx_r + LW'(issue_s);
                    scan_vld_nx_s  = issue_s;
                    scan_last_nx_s = issue_s && (scan_idx_r == length_r - ONE_LEN);
                    if (hit_s) begin
                        fsm_nx_s = FSM_SPAWN;
                    end else if (done_s) begin
                        food_nx_s     = cand_r;
                        has_food_nx_s = 1'b1;
                        fsm_nx_s      = FSM_IDLE;
                    end else begin
                        fsm_nx_s = FSM_FSCAN;
                    end
                end
                FSM_MOVE: begin
                    heading_nx_s = move_dir_s;
                    if (off_s) begin
                        lose_nx_s = 1'b1;
                        fsm_nx_s  = FSM_IDLE;
                    end else begin
                        head_ptr_nx_s = head_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                        head_nx_s     = new_head_s;
                        ram_we_s      = 1'b1;
                        ram_waddr_s   = head_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                        scan_idx_nx_s = ONE_LEN;
                        fsm_nx_s      = FSM_CSCAN;
                    end
                end
                FSM_CSCAN: begin
                    scan_idx_nx_s  = scan_idx_r + LW'(issue_s);
                    scan_vld_nx_s  = issue_s;
                    scan_last_nx_s = issue_s && (scan_idx_r == length_r - ONE_LEN);
                    if (hit_s) begin
                        lose_nx_s = 1'b1;
                        fsm_nx_s  = FSM_IDLE;
                    end else if (done_s) begin
                        fsm_nx_s = FSM_EAT;
                    end else begin
                        fsm_nx_s = FSM_CSCAN;
                    end
                end
                FSM_EAT: begin
                    if (head_r == food_r && has_food_r) begin
                        has_food_nx_s   = 1'b0;
                        food_eaten_nx_s = 1'b1;
                        length_nx_s     = length_r + ONE_LEN;
                        win_nx_s        = (length_r + ONE_LEN == FULL_LEN);
                    end else begin
                        has_food_nx_s = has_food_r;
                    end
                    fsm_nx_s = FSM_IDLE;
                end
                default: begin
                    fsm_nx_s = FSM_IDLE;
                end
            endcase
            // One-deep step buffer; a step arriving while one is already held is dropped.
            if (take_s) begin
                pending_nx_s = pending_r && step;
            end else if (step && state == game_state && !frozen_s) begin
                pending_nx_s = 1'b1;
            end else begin
                pending_nx_s = pending_r;
            end
            busy_nx_s = (fsm_nx_s != FSM_IDLE);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_r        <= FSM_IDLE;
            head_ptr_r   <= {AW{1'b0}};
            head_r       <= INIT_HEAD;
            food_r       <= '{x: {COORD_W{1'b0}}, y: {COORD_W{1'b0}}};
            cand_r       <= '{x: {COORD_W{1'b0}}, y: {COORD_W{1'b0}}};
            heading_r    <= DIR_RIGHT;
            length_r     <= ONE_LEN;
            has_food_r   <= 1'b0;
            food_eaten_r <= 1'b0;
            lose_r       <= 1'b0;
            win_r        <= 1'b0;
            busy_r       <= 1'b0;
            pending_r    <= 1'b0;
            scan_idx_r   <= {LW{1'b0}};
            scan_vld_r   <= 1'b0;
            scan_last_r  <= 1'b0;
        end else begin
            fsm_r        <= fsm_nx_s;
            head_ptr_r   <= head_ptr_nx_s;
            head_r       <= head_nx_s;
            food_r       <= food_nx_s;
            cand_r       <= cand_nx_s;
            heading_r    <= heading_nx_s;
            length_r     <= length_nx_s;
            has_food_r   <= has_food_nx_s;
            food_eaten_r <= food_eaten_nx_s;
            lose_r       <= lose_nx_s;
            win_r        <= win_nx_s;
            busy_r       <= busy_nx_s;
            pending_r    <= pending_nx_s;
            scan_idx_r   <= scan_idx_nx_s;
            scan_vld_r   <= scan_vld_nx_s;
            scan_last_r  <= scan_last_nx_s;
        end
    end

    assign head       = head_r;
    assign length     = length_r;
    assign food       = food_r;
    assign has_food   = has_food_r;
    assign food_eaten = food_eaten_r;
    assign lose       = lose_r;
    assign win        = win_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_snake_engine.sv
// Directed self-checking bench for snake_engine (40x30 grid, 64 segments);
// expected edge behaviour follows SNAKE_WRAP_EN.
module tb_snake_engine;
    import snake_pkg::*;

    logic        clock;
    logic        reset;
    state_t      state;
    direction_t  direction;
    logic        step;
    logic [31:0] rand_x;
    logic [31:0] rand_y;
    logic [5:0]  rd_idx;
    point_t      rd_seg;
    point_t      head;
    logic [6:0]  length;
    point_t      food;
    logic        has_food;
    logic        food_eaten;
    logic        lose;
    logic        win;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int eaten;

    snake_engine dut (
        .clock      (clock),
        .reset      (reset),
        .state      (state),
        .direction  (direction),
        .step       (step),
        .rand_x     (rand_x),
        .rand_y     (rand_y),
        .rd_idx     (rd_idx),
        .rd_seg     (rd_seg),
        .head       (head),
        .length     (length),
        .food       (food),
        .has_food   (has_food),
        .food_eaten (food_eaten),
        .lose       (lose),
        .win        (win),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] pt(input int x, input int y);
        logic [7:0] xb;
        logic [7:0] yb;
        xb = 8'(x);
        yb = 8'(y);
        return {16'd0, xb, yb};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One step pulse, then a window long enough for the worst-case service.
    task automatic do_step(output int n_eaten);
        n_eaten = 0;
        @(negedge clock);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        for (int i = 0; i < 90; i++) begin
            if (food_eaten === 1'b1) n_eaten++;
            @(negedge clock);
        end
    endtask

    initial begin
        reset = 1'b1; state = initial_state; direction = DIR_RIGHT; step = 1'b0;
        rand_x = 32'd45; rand_y = 32'd35; rd_idx = 6'd0;
        cycles(3);
        reset = 1'b0;
        cycles(1);
        check("rst_length", 32'(length), 32'd1);
        check("rst_head", {16'd0, head}, pt(20, 15));
        check("rst_food", {16'd0, food}, pt(0, 0));
        check("rst_flags", {27'd0, has_food, food_eaten, lose, win, busy}, 32'd0);

        // First food spawn: 45%40=5, 35%30=5.
        state = game_state;
        cycles(90);
        check("spawn_food", {16'd0, food}, pt(5, 5));
        check("spawn_valid", 32'(has_food), 32'd1);

        // Three steps right; the third requests a reversal which is ignored.
        do_step(eaten);
        do_step(eaten);
        direction = DIR_LEFT;
        do_step(eaten);
        check("move3_head", {16'd0, head}, pt(23, 15));
        check("move3_length", 32'(length), 32'd1);
        check("move3_lose", 32'(lose), 32'd0);

        rd_idx = 6'd0;
        cycles(2);
        check("rd_seg0", {16'd0, rd_seg}, pt(23, 15));
        rd_idx = 6'd2;
        cycles(2);
        check("rd_seg2", {16'd0, rd_seg}, pt(21, 15));

        direction = DIR_RIGHT;
        for (int i = 0; i < 16; i++) do_step(eaten);
        check("edge_head", {16'd0, head}, pt(39, 15));
        do_step(eaten);
`ifdef SNAKE_WRAP_EN
        check("wrap_head", {16'd0, head}, pt(0, 15));
        check("wrap_lose", 32'(lose), 32'd0);
`else
        check("edge_head_held", {16'd0, head}, pt(39, 15));
        check("edge_lose", 32'(lose), 32'd1);
`endif

        // Restart with food directly ahead.
        state = initial_state;
        cycles(2);
        check("init_lose", 32'(lose), 32'd0);
        check("init_head", {16'd0, head}, pt(20, 15));
        check("init_has_food", 32'(has_food), 32'd0);
        rand_x = 32'd21; rand_y = 32'd15;
        state = game_state;
        cycles(90);
        check("food_ahead", {16'd0, food}, pt(21, 15));

        // Next spawn candidate lands on the tail, so spawning keeps retrying.
        rand_x = 32'd20; rand_y = 32'd15;
        do_step(eaten);
        check("eat_pulse_cycles", 32'(eaten), 32'd1);
        check("eat_length", 32'(length), 32'd2);
        check("eat_head", {16'd0, head}, pt(21, 15));
        cycles(20);
        check("respawn_blocked", 32'(has_food), 32'd0);
        rand_x = 32'd142; rand_y = 32'd15;
        cycles(90);
        check("respawn_food", {16'd0, food}, pt(22, 15));
        check("respawn_valid", 32'(has_food), 32'd1);
        rd_idx = 6'd1;
        cycles(2);
        check("rd_tail", {16'd0, rd_seg}, pt(20, 15));

        // Grow to five segments in a straight line.
        rand_x = 32'd23; rand_y = 32'd15;
        do_step(eaten);
        rand_x = 32'd24; rand_y = 32'd15;
        do_step(eaten);
        rand_x = 32'd5; rand_y = 32'd5;
        do_step(eaten);
        check("grow_length", 32'(length), 32'd5);
        check("grow_head", {16'd0, head}, pt(24, 15));
        check("grow_food", {16'd0, food}, pt(5, 5));

        // U-turn into the body: (24,14), (23,14), then (23,15) is segment 3.
        direction = DIR_UP;
        do_step(eaten);
        check("u_up_head", {16'd0, head}, pt(24, 14));
        direction = DIR_LEFT;
        do_step(eaten);
        check("u_left_lose", 32'(lose), 32'd0);
        direction = DIR_DOWN;
        do_step(eaten);
        check("collide_lose", 32'(lose), 32'd1);
        check("collide_head", {16'd0, head}, pt(23, 15));
        do_step(eaten);
        check("frozen_head", {16'd0, head}, pt(23, 15));
        check("frozen_lose", 32'(lose), 32'd1);
        check("frozen_win", 32'(win), 32'd0);

        state = initial_state;
        cycles(2);
        check("clear_lose", 32'(lose), 32'd0);

        // Three back-to-back step pulses: one serviced, one pending, one dropped.
        direction = DIR_RIGHT;
        state = game_state;
        cycles(90);
        @(negedge clock);
        step = 1'b1;
        cycles(3);
        step = 1'b0;
        cycles(90);
        check("pending_head", {16'd0, head}, pt(22, 15));
        check("pending_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
